// File: rtl/xbar_pipe.sv
// xbar_pipe: parametrised, registered PORTS x PORTS crossbar for the
// credit-based router datapath. Each output register loads the input
// flit picked by its one-hot select and holds it while downstream stalls.
//
// Parameters:
//   DATA_WIDTH  flit width in bits
//   PORTS       number of input and output ports
//                 (0 Local, 1 South, 2 West, 3 East, 4 North)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   data_in    input flits, input i at [i*DATA_WIDTH +: DATA_WIDTH]
//   valid_in   per-input flit valid
//   sel        one-hot select per output, output o at [o*PORTS +: PORTS]
//   stall      per-output downstream stall
//   data_out   registered output flits
//   valid_out  per-output valid
//   err_clr    clears sticky error flags
//   err_sel    sticky: output saw a multi-hot select
//   err_drop   sticky: output lost a flit to a stall
//
// Optional feature macro: XBAR_PIPE_CHECK_EN enables the error checker.
// Without it err_sel/err_drop are tied to 0 and err_clr is ignored.
module xbar_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int PORTS      = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PORTS*DATA_WIDTH-1:0] data_in,
  input  logic [PORTS-1:0]            valid_in,
  input  logic [PORTS*PORTS-1:0]      sel,
  input  logic [PORTS-1:0]            stall,
  output logic [PORTS*DATA_WIDTH-1:0] data_out,
  output logic [PORTS-1:0]            valid_out,
  input  logic                        err_clr,
  output logic [PORTS-1:0]            err_sel,
  output logic [PORTS-1:0]            err_drop
);

  logic [PORTS-1:0]                 load;
  logic [PORTS-1:0]                 sel_any;
  logic [PORTS-1:0]                 sel_multi;
  logic [PORTS-1:0]                 pick_valid;
  logic [PORTS-1:0][DATA_WIDTH-1:0] pick_data;

  // OR-reduction mux: the result is only consumed when the select is
  // one-hot, so OR-ing all selected inputs yields exactly that input.
  always_comb begin
    load       = '0;
    sel_any    = '0;
    sel_multi  = '0;
    pick_valid = '0;
    pick_data  = '0;
    for (int unsigned o = 0; o < PORTS; o++) begin
      load[o] = !(valid_out[o] && stall[o]);
      for (int unsigned i = 0; i < PORTS; i++) begin
        if (sel[o*PORTS + i]) begin
          if (sel_any[o]) sel_multi[o] = 1'b1;
          sel_any[o]    = 1'b1;
          pick_valid[o] = pick_valid[o] | valid_in[i];
          pick_data[o]  = pick_data[o] | data_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= '0;
    end else begin
      for (int unsigned o = 0; o < PORTS; o++) begin
        if (load[o]) begin
          if (sel_any[o] && !sel_multi[o]) begin
            data_out[o*DATA_WIDTH +: DATA_WIDTH] <= pick_data[o];
            valid_out[o]                         <= pick_valid[o];
          end else begin
            // Zero or multi-hot select: drop valid, keep stale data.
            valid_out[o] <= 1'b0;
          end
        end
      end
    end
  end

`ifdef XBAR_PIPE_CHECK_EN
  // A set event in the same cycle as err_clr wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_sel  <= '0;
      err_drop <= '0;
    end else begin
      for (int unsigned o = 0; o < PORTS; o++) begin
        if (sel_multi[o])    err_sel[o] <= 1'b1;
        else if (err_clr)    err_sel[o] <= 1'b0;
        if (valid_out[o] && stall[o] && sel_any[o] && pick_valid[o])
          err_drop[o] <= 1'b1;
        else if (err_clr)
          err_drop[o] <= 1'b0;
      end
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_sel  = '0;
  assign err_drop = '0;
`endif

endmodule

// File: tb/tb_xbar_pipe.sv
// tb_xbar_pipe: directed self-checking bench for xbar_pipe with
// PORTS = 5 and DATA_WIDTH = 32. Error-flag expectations follow the
// XBAR_PIPE_CHECK_EN setting of the build.
module tb_xbar_pipe;

  localparam int DW = 32;
  localparam int NP = 5;
`ifdef XBAR_PIPE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NP*DW-1:0]     data_in;
  logic [NP-1:0]        valid_in;
  logic [NP*NP-1:0]     sel;
  logic [NP-1:0]        stall;
  logic [NP*DW-1:0]     data_out;
  logic [NP-1:0]        valid_out;
  logic                 err_clr;
  logic [NP-1:0]        err_sel;
  logic [NP-1:0]        err_drop;

  int checks = 0;
  int fails  = 0;

  xbar_pipe #(.DATA_WIDTH(DW), .PORTS(NP)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .sel       (sel),
    .stall     (stall),
    .data_out  (data_out),
    .valid_out (valid_out),
    .err_clr   (err_clr),
    .err_sel   (err_sel),
    .err_drop  (err_drop)
  );

  always #5 clk = ~clk;

  // Advance one edge and sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_din(input int i, input logic [DW-1:0] v);
    data_in[i*DW +: DW] = v;
  endtask

  task automatic set_sel(input int o, input logic [NP-1:0] v);
    sel[o*NP +: NP] = v;
  endtask

  function automatic logic [DW-1:0] dout(input int o);
    return data_out[o*DW +: DW];
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    step();
    checks++;
    if (data_out !== '0) begin
      fails++; $display("FAIL reset_data: got %h expected 0", data_out);
    end
    checks++;
    if (valid_out !== 5'b00000) begin
      fails++; $display("FAIL reset_valid: got %b expected 00000", valid_out);
    end
    checks++;
    if (err_sel !== 5'b00000 || err_drop !== 5'b00000) begin
      fails++; $display("FAIL reset_err: got sel=%b drop=%b expected 0/0", err_sel, err_drop);
    end
    reset = 1'b0;
  endtask

  task automatic test_straight();
    for (int i = 0; i < NP; i++) begin
      set_din(i, 32'hA0 + i);
      set_sel(i, 5'b00001 << i);
    end
    valid_in = 5'b11111;
    step();
    for (int o = 0; o < NP; o++) begin
      checks++;
      if (dout(o) !== 32'hA0 + o) begin
        fails++; $display("FAIL straight_data%0d: got %h expected %h", o, dout(o), 32'hA0 + o);
      end
    end
    checks++;
    if (valid_out !== 5'b11111) begin
      fails++; $display("FAIL straight_valid: got %b expected 11111", valid_out);
    end
  endtask

  task automatic test_multicast();
    set_din(2, 32'hDEADBEEF);
    for (int o = 0; o < NP; o++) set_sel(o, 5'b00100);
    step();
    for (int o = 0; o < NP; o++) begin
      checks++;
      if (dout(o) !== 32'hDEADBEEF) begin
        fails++; $display("FAIL multicast_data%0d: got %h expected deadbeef", o, dout(o));
      end
    end
    checks++;
    if (valid_out !== 5'b11111) begin
      fails++; $display("FAIL multicast_valid: got %b expected 11111", valid_out);
    end
    checks++;
    if (err_sel !== 5'b00000) begin
      fails++; $display("FAIL multicast_err_sel: got %b expected 00000", err_sel);
    end
  endtask

  task automatic test_stall_hold();
    set_sel(3, 5'b01000);
    set_din(3, 32'h11);
    step();
    checks++;
    if (dout(3) !== 32'h11 || valid_out[3] !== 1'b1) begin
      fails++; $display("FAIL stall_preload: got %h/%b expected 11/1", dout(3), valid_out[3]);
    end
    stall[3] = 1'b1;
    set_din(3, 32'h22);
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (dout(3) !== 32'h11 || valid_out[3] !== 1'b1) begin
        fails++; $display("FAIL stall_hold%0d: got %h/%b expected 11/1", k, dout(3), valid_out[3]);
      end
    end
    checks++;
    if (dout(0) !== 32'hDEADBEEF) begin
      fails++; $display("FAIL stall_independent: got %h expected deadbeef", dout(0));
    end
    checks++;
    if (err_drop !== (CHK ? 5'b01000 : 5'b00000)) begin
      fails++; $display("FAIL stall_err_drop: got %b expected %b", err_drop, CHK ? 5'b01000 : 5'b00000);
    end
    stall[3] = 1'b0;
    set_din(3, 32'h33);
    step();
    checks++;
    if (dout(3) !== 32'h33 || valid_out[3] !== 1'b1) begin
      fails++; $display("FAIL stall_release: got %h/%b expected 33/1", dout(3), valid_out[3]);
    end
    checks++;
    if (err_drop !== (CHK ? 5'b01000 : 5'b00000)) begin
      fails++; $display("FAIL drop_sticky: got %b expected %b", err_drop, CHK ? 5'b01000 : 5'b00000);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++;
    if (err_drop !== 5'b00000) begin
      fails++; $display("FAIL drop_clear: got %b expected 00000", err_drop);
    end
  endtask

  task automatic test_bad_select();
    set_sel(1, 5'b00110);
    step();
    checks++;
    if (valid_out !== 5'b11101) begin
      fails++; $display("FAIL badsel_valid: got %b expected 11101", valid_out);
    end
    checks++;
    if (dout(1) !== 32'hDEADBEEF) begin
      fails++; $display("FAIL badsel_data: got %h expected deadbeef", dout(1));
    end
    checks++;
    if (err_sel !== (CHK ? 5'b00010 : 5'b00000)) begin
      fails++; $display("FAIL badsel_err: got %b expected %b", err_sel, CHK ? 5'b00010 : 5'b00000);
    end
    // Clear coincident with a fresh set event: the flag must stay set.
    err_clr = 1'b1;
    step();
    checks++;
    if (err_sel !== (CHK ? 5'b00010 : 5'b00000)) begin
      fails++; $display("FAIL badsel_set_wins: got %b expected %b", err_sel, CHK ? 5'b00010 : 5'b00000);
    end
    set_sel(1, 5'b00010);
    step();
    err_clr = 1'b0;
    checks++;
    if (err_sel !== 5'b00000) begin
      fails++; $display("FAIL badsel_clear: got %b expected 00000", err_sel);
    end
    checks++;
    if (dout(1) !== 32'hA1 || valid_out[1] !== 1'b1) begin
      fails++; $display("FAIL badsel_recover: got %h/%b expected a1/1", dout(1), valid_out[1]);
    end
  endtask

  task automatic test_zero_invalid();
    set_sel(0, 5'b00000);
    step();
    checks++;
    if (valid_out[0] !== 1'b0 || dout(0) !== 32'hDEADBEEF) begin
      fails++; $display("FAIL zerosel: got %h/%b expected deadbeef/0", dout(0), valid_out[0]);
    end
    set_sel(0, 5'b10000);
    valid_in[4] = 1'b0;
    set_din(4, 32'h55);
    step();
    checks++;
    if (valid_out[0] !== 1'b0 || dout(0) !== 32'h55) begin
      fails++; $display("FAIL invalid_in: got %h/%b expected 55/0", dout(0), valid_out[0]);
    end
    valid_in = 5'b11111;
  endtask

  task automatic test_stall_no_valid();
    stall[0] = 1'b1;
    set_sel(0, 5'b00001);
    set_din(0, 32'h77);
    step();
    checks++;
    if (dout(0) !== 32'h77 || valid_out[0] !== 1'b1) begin
      fails++; $display("FAIL stall_idle_load: got %h/%b expected 77/1", dout(0), valid_out[0]);
    end
    stall[0] = 1'b0;
  endtask

  task automatic test_back_to_back();
    set_sel(2, 5'b00100);
    for (int k = 0; k < 4; k++) begin
      set_din(2, 32'h100 + k);
      step();
      checks++;
      if (dout(2) !== 32'h100 + k || valid_out[2] !== 1'b1) begin
        fails++; $display("FAIL b2b_%0d: got %h/%b expected %h/1", k, dout(2), valid_out[2], 32'h100 + k);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    for (int i = 0; i < NP; i++) begin
      set_din(i, 32'hB0 + i);
      set_sel(i, 5'b00001 << i);
    end
    valid_in = 5'b11111;
    step();
    stall = 5'b11111;
    step();
    checks++;
    if (valid_out !== 5'b11111 || dout(4) !== 32'hB4) begin
      fails++; $display("FAIL midstall_pre: got %b/%h expected 11111/b4", valid_out, dout(4));
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    stall = 5'b00000;
    checks++;
    if (data_out !== '0 || valid_out !== 5'b00000) begin
      fails++; $display("FAIL midstall_reset: got %h/%b expected 0/0", data_out, valid_out);
    end
    checks++;
    if (err_sel !== 5'b00000 || err_drop !== 5'b00000) begin
      fails++; $display("FAIL midstall_err: got %b/%b expected 0/0", err_sel, err_drop);
    end
  endtask

  initial begin
    reset    = 1'b1;
    data_in  = '0;
    valid_in = '0;
    sel      = '0;
    stall    = '0;
    err_clr  = 1'b0;
    test_reset();
    test_straight();
    test_multicast();
    test_stall_hold();
    test_bad_select();
    test_zero_invalid();
    test_stall_no_valid();
    test_back_to_back();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/xbar_pipe.md
# xbar_pipe

Parametrised, registered N×N crossbar for the credit-based router datapath. It is the generalised successor of the single-output, 5-input combinational crossbar. For every output port, it routes one of PORTS input flits, chosen by a one-hot select, into an output register with a valid bit. The register holds its flit while the downstream stage stalls. The block sits between the input FIFOs and the output links, and the allocator drives its selects.

## Interface
Parameters:
- DATA_WIDTH, 32, flit width in bits
- PORTS, 5, number of input ports and of output ports (index 0 = Local, 1 = South, 2 = West, 3 = East, 4 = North when PORTS = 5)

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- data_in  input  PORTS*DATA_WIDTH  input flits; input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- valid_in  input  PORTS  input i presents a flit this cycle.
- sel  input  PORTS*PORTS  one-hot select per output; output o uses bits [o*PORTS +: PORTS], and bit i selects input i.
- stall  input  PORTS  downstream of output o cannot accept a flit this cycle.
- data_out  output  PORTS*DATA_WIDTH  registered output flits.
- valid_out  output  PORTS  data_out slice o holds a valid flit.
- err_clr  input  1  clears sticky error flags (only with XBAR_PIPE_CHECK_EN).
- err_sel  output  PORTS  sticky flag: output o saw a multi-hot select (only with XBAR_PIPE_CHECK_EN).
- err_drop  output  PORTS  sticky flag: output o lost a flit to a stall (only with XBAR_PIPE_CHECK_EN).

## Operation
- Per output o: load = !(valid_out[o] && stall[o]).
- If load and sel_o has exactly one bit i set: data_out_o <= data_in_i and valid_out[o] <= valid_in[i].
- If load and sel_o is zero or multi-hot: valid_out[o] <= 0 and data_out_o holds its previous value. The block never falls back to a default input.
- If !load: data_out_o and valid_out[o] both hold.
- One input may feed several outputs in the same cycle (multicast is legal). Outputs are fully independent.
- Selecting an input whose valid_in is 0 produces valid_out = 0 and still loads the data field.
- The allocator must not issue a select to a stalled output. When it does, the incoming flit is discarded and the held flit is preserved.
- Reset: data_out = 0, valid_out = 0, err_sel = 0, err_drop = 0.

## Timing
- Latency is exactly 1 cycle from select and data to data_out / valid_out.
- stall is sampled in the same cycle as the candidate load. Any valid_out flit that sees stall low in a cycle counts as transferred at that edge.
- When a flit is held under stall, it is presented unchanged on every cycle until the first cycle with stall low. The next flit appears at the following edge.
- If stall is asserted while valid_out = 0, it has no effect; the register loads normally.
- If reset is asserted mid-stall, the held flit is discarded at the next edge and valid_out drops to 0.
- Throughput is one flit per output per cycle when stall stays low.

## Configuration
- XBAR_PIPE_CHECK_EN defined:
  - err_sel[o] sets on any cycle where sel_o has two or more bits set.
  - err_drop[o] sets when valid_out[o] && stall[o] && sel_o is nonzero && the selected valid_in is 1.
  - Both flags are sticky until err_clr or reset. If err_clr and a new set event occur in the same cycle, the flag is set.
- XBAR_PIPE_CHECK_EN undefined:
  - err_sel and err_drop are tied to 0.
  - No checker logic is synthesised.
  - Datapath behaviour is identical to the defined case.

## Test plan
- Straight routing (PORTS = 5, DATA_WIDTH = 32): data_in_i = 0xA0+i, all valid, sel_o = 1<<o -> one cycle later, data_out_o = 0xA0+o and valid_out = 5'b11111.
- Multicast: sel for every output = 5'b00100, data_in_2 = 0xDEADBEEF -> every data_out = 0xDEADBEEF and valid_out = 5'b11111.
- Stall hold: valid_out[3] = 1 holding 0x11, stall[3] = 1 for 3 cycles while 0x22 is offered -> data_out_3 stays 0x11 for all 3 cycles. With CHECK_EN, err_drop[3] = 1. Once stall is released and a new load is issued, 0x33 appears the next cycle.
- Bad select: sel_1 = 5'b00110 -> valid_out[1] = 0 and data_out_1 unchanged. With CHECK_EN, err_sel = 5'b00010 until err_clr is pulsed, after which it reads 0.
- Zero select and invalid input: sel_0 = 0 -> valid_out[0] = 0. Then sel_0 = 5'b10000 with valid_in[4] = 0 -> valid_out[0] = 0 and data_out_0 = data_in_4.
- Reset mid-stall: valid_out = 5'b11111 with stall = 5'b11111, then reset is asserted for 1 cycle -> all outputs and error flags read 0 at the next edge.
